// File: rtl/palette_fade_ctrl_pkg.sv
// Shared types and helpers for the palette brightness/fade sequencer.
package fade_pkg;

  typedef enum logic [1:0] {
    LIT      = 2'd0,
    FADE_OUT = 2'd1,
    DARK     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  localparam int LEVEL_W   = 5;
  localparam int LEVEL_MAX = 16;

  // Decrease a brightness level by step, saturating at zero.
  function automatic logic [LEVEL_W-1:0] level_down(input logic [LEVEL_W-1:0] lvl,
                                                    input logic [LEVEL_W-1:0] stp);
    logic [LEVEL_W-1:0] res;
    if (lvl > stp) begin
      res = lvl - stp;
    end else begin
      res = {LEVEL_W{1'b0}};
    end
    return res;
  endfunction

  // Increase a brightness level by step, saturating at full brightness.
  function automatic logic [LEVEL_W-1:0] level_up(input logic [LEVEL_W-1:0] lvl,
                                                  input logic [LEVEL_W-1:0] stp);
    logic [LEVEL_W:0]   sum;
    logic [LEVEL_W-1:0] res;
    sum = {1'b0, lvl} + {1'b0, stp};
    if (sum >= (LEVEL_W+1)'(LEVEL_MAX)) begin
      res = LEVEL_W'(LEVEL_MAX);
    end else begin
      res = sum[LEVEL_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/palette_fade_ctrl_scale.sv
// Combinational colour scaler: 4-bit channel times 0..16 brightness, divided by 16.
module palette_scale
  import fade_pkg::*;
(
  input  logic [3:0]         i_colour,
  input  logic [LEVEL_W-1:0] i_level,
  output logic [3:0]         o_scaled
);

  logic [8:0] w_product;

  // Level 16 gives colour*16, so bits [7:4] return the channel unchanged.
  assign w_product = {5'd0, i_colour} * {4'd0, i_level};
  assign o_scaled  = w_product[7:4];

endmodule

// File: rtl/palette_fade_ctrl.sv
// Brightness/fade sequencer between the palette lookup and the VGA colour pins.
// Steps the brightness level once every FRAMES_PER_STEP frames while fading.
module palette_fade_ctrl
  import fade_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2,
  parameter int LEVEL_STEP      = 1,
  parameter int START_DARK      = 0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               vs,
  input  logic               fade_out_req,
  input  logic               fade_in_req,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic [3:0]         Red,
  output logic [3:0]         Green,
  output logic [3:0]         Blue,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               fade_done
);

  localparam int CNT_W = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [LEVEL_W-1:0] STEP_L      = LEVEL_W'(LEVEL_STEP);
  localparam logic [LEVEL_W-1:0] LVL_FULL    = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_ZERO    = {LEVEL_W{1'b0}};
  localparam fade_state_t        RESET_STATE = (START_DARK != 0) ? DARK : LIT;
  localparam logic [LEVEL_W-1:0] RESET_LEVEL = (START_DARK != 0) ? LVL_ZERO : LVL_FULL;

  fade_state_t        r_state;
  logic [LEVEL_W-1:0] r_level;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic               r_vs_q;
  logic               r_fade_done;
  logic [3:0]         r_red;
  logic [3:0]         r_green;
  logic [3:0]         r_blue;

  logic               w_frame_tick;
  logic               w_step_due;
  logic [LEVEL_W-1:0] w_level_dn;
  logic [LEVEL_W-1:0] w_level_up;
  logic [3:0]         w_red;
  logic [3:0]         w_green;
  logic [3:0]         w_blue;

  // Falling edge of the active-low sync marks exactly one tick per frame.
  assign w_frame_tick = r_vs_q & ~vs;
  assign w_step_due   = w_frame_tick && (r_frame_cnt == CNT_LAST);
  assign w_level_dn   = level_down(r_level, STEP_L);
  assign w_level_up   = level_up(r_level, STEP_L);

  palette_scale u_scale_red   (.i_colour(pal_red),   .i_level(r_level), .o_scaled(w_red));
  palette_scale u_scale_green (.i_colour(pal_green), .i_level(r_level), .o_scaled(w_green));
  palette_scale u_scale_blue  (.i_colour(pal_blue),  .i_level(r_level), .o_scaled(w_blue));

  // Fade state machine: request handling, frame counting and level stepping.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state     <= RESET_STATE;
      r_level     <= RESET_LEVEL;
      r_frame_cnt <= {CNT_W{1'b0}};
      r_vs_q      <= 1'b1;
      r_fade_done <= 1'b0;
    end else begin
      r_vs_q      <= vs;
      r_fade_done <= 1'b0;
      case (r_state)
        LIT: begin
          if (fade_out_req) begin
            r_state     <= FADE_OUT;
            r_frame_cnt <= {CNT_W{1'b0}};
          end
        end
        DARK: begin
          // fade_out_req takes priority and is meaningless here, so it masks fade_in_req.
          if (!fade_out_req && fade_in_req) begin
            r_state     <= FADE_IN;
            r_frame_cnt <= {CNT_W{1'b0}};
          end
        end
        FADE_OUT: begin
          if (!fade_out_req && fade_in_req) begin
            r_state     <= FADE_IN;
            r_frame_cnt <= {CNT_W{1'b0}};
          end else if (w_step_due) begin
            r_frame_cnt <= {CNT_W{1'b0}};
            r_level     <= w_level_dn;
            if (w_level_dn == LVL_ZERO) begin
              r_state     <= DARK;
              r_fade_done <= 1'b1;
            end
          end else if (w_frame_tick) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          end
        end
        FADE_IN: begin
          if (fade_out_req) begin
            r_state     <= FADE_OUT;
            r_frame_cnt <= {CNT_W{1'b0}};
          end else if (w_step_due) begin
            r_frame_cnt <= {CNT_W{1'b0}};
            r_level     <= w_level_up;
            if (w_level_up == LVL_FULL) begin
              r_state     <= LIT;
              r_fade_done <= 1'b1;
            end
          end else if (w_frame_tick) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= RESET_STATE;
          r_level     <= RESET_LEVEL;
          r_frame_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Colour output registers: palette scaled by the level held before this edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_red   <= 4'd0;
      r_green <= 4'd0;
      r_blue  <= 4'd0;
    end else begin
      r_red   <= w_red;
      r_green <= w_green;
      r_blue  <= w_blue;
    end
  end

  assign Red       = r_red;
  assign Green     = r_green;
  assign Blue      = r_blue;
  assign level     = r_level;
  assign busy      = (r_state == FADE_OUT) || (r_state == FADE_IN);
  assign fade_done = r_fade_done;

endmodule
